// File: rtl/dm_store_buffer.sv
// Byte-enable store FIFO in front of a word-only data memory: drains with read-merge-write
// whenever the port is free, and forwards queued bytes to loads so they never see stale data.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [11:2] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        empty,
    output logic [11:2] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [11:2]   addr_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, head_d, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic        full;
    logic        push;
    logic        drain;
    logic [31:0] merge_word;
    logic [31:0] fwd_word;
    logic [PW-1:0] fwd_idx;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // While reset is asserted nothing is pushed, popped or written.
    assign push  = clr_n & cpu_we & ~full;
    assign stall = clr_n & cpu_we & full;
    assign drain = clr_n & ~cpu_re & ~empty;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merge_word[8*gi +: 8] = be_q[head_q][gi] ? data_q[head_q][8*gi +: 8]
                                                           : dm_dout[8*gi +: 8];
        end
    endgenerate

    assign dm_we   = drain;
    assign dm_addr = drain ? addr_q[head_q] : cpu_addr;
    assign dm_din  = drain ? merge_word : 32'h0;

    // Oldest-to-youngest overlay so the youngest matching store wins each byte.
    always_comb begin
        fwd_word = dm_dout;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == cpu_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[fwd_idx][b]) begin
                        fwd_word[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign cpu_rdata = fwd_word;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        case ({push, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= cpu_addr;
            be_q[tail_q]   <= cpu_be;
            data_q[tail_q] <= cpu_wdata;
        end
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with a behavioural word memory on the dm_* port.
module tb_dm_store_buffer;
    logic        clk = 1'b0;
    logic        clr_n;
    logic [11:2] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        empty;
    logic [11:2] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];
    logic        mem_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cpu_addr  (cpu_addr),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .empty     (empty),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_we     (dm_we),
        .dm_dout   (dm_dout)
    );

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[5] <= 32'h11223344;
        end else if (dm_we) begin
            mem[dm_addr] <= dm_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] d);
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = d;
        #1;
    endtask

    initial begin
        clr_n    = 1'b0;
        mem_load = 1'b1;
        drive(1'b1, 1'b0, 10'd9, 4'hF, 32'hCAFE0000);
        check("rst0_dm_we", {31'b0, dm_we}, 32'd0);
        check("rst0_stall", {31'b0, stall}, 32'd0);
        tick();
        check("rst1_empty", {31'b0, empty}, 32'd1);
        check("rst1_dm_we", {31'b0, dm_we}, 32'd0);
        check("rst1_stall", {31'b0, stall}, 32'd0);
        check("rst1_dm_din", dm_din, 32'h0);
        check("rst1_dm_addr", {22'b0, dm_addr}, 32'd9);
        tick();
        clr_n    = 1'b1;
        mem_load = 1'b0;
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        check("rel_empty", {31'b0, empty}, 32'd1);
        check("rel_dm_we", {31'b0, dm_we}, 32'd0);

        // Byte merge into 0x11223344 at word 5
        drive(1'b1, 1'b0, 10'd5, 4'b0010, 32'h0000AA00);
        check("bm_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        check("bm_dm_we", {31'b0, dm_we}, 32'd1);
        check("bm_dm_addr", {22'b0, dm_addr}, 32'd5);
        check("bm_dm_din", dm_din, 32'h1122AA44);
        tick();
        check("bm_mem5", mem[5], 32'h1122AA44);
        check("bm_empty", {31'b0, empty}, 32'd1);

        // Forwarding under continuous loads
        drive(1'b1, 1'b0, 10'd3, 4'hF, 32'hDEADBEEF);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b1, 10'd3, 4'h0, 32'h0);
            check($sformatf("fw_rdata%0d", c), cpu_rdata, 32'hDEADBEEF);
            check($sformatf("fw_dm_we%0d", c), {31'b0, dm_we}, 32'd0);
            check($sformatf("fw_empty%0d", c), {31'b0, empty}, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        check("fw_drain_addr", {22'b0, dm_addr}, 32'd3);
        tick();
        check("fw_mem3", mem[3], 32'hDEADBEEF);

        // Youngest store wins per byte (re&we pushes without draining)
        drive(1'b1, 1'b1, 10'd7, 4'hF, 32'h01020304);
        tick();
        drive(1'b1, 1'b1, 10'd7, 4'b0001, 32'h000000FF);
        tick();
        drive(1'b0, 1'b1, 10'd7, 4'h0, 32'h0);
        check("yw_rdata", cpu_rdata, 32'h010203FF);
        check("yw_dm_addr", {22'b0, dm_addr}, 32'd7);
        tick();
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        tick();
        tick();
        check("yw_mem7", mem[7], 32'h010203FF);
        check("yw_empty", {31'b0, empty}, 32'd1);

        // Back-to-back stores: each drains the previous one, never fills
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 10'(16 + k), 4'hF, 32'hA0000000 + 32'(k));
            check($sformatf("bb_stall%0d", k), {31'b0, stall}, 32'd0);
            check($sformatf("bb_dm_we%0d", k), {31'b0, dm_we}, (k == 0) ? 32'd0 : 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        check("bb_last_addr", {22'b0, dm_addr}, 32'd19);
        tick();
        check("bb_empty", {31'b0, empty}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bb_mem%0d", k), mem[16 + k], 32'hA0000000 + 32'(k));
        end

        // Fill to 4, fifth store stalls exactly one cycle, pointers wrap
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 10'(32 + k), 4'hF, 32'hB0000000 + 32'(k));
            check($sformatf("fl_stall%0d", k), {31'b0, stall}, 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 10'd36, 4'hF, 32'hB0000004);
        check("fl_stall_full", {31'b0, stall}, 32'd1);
        check("fl_drain_we", {31'b0, dm_we}, 32'd1);
        check("fl_drain_addr0", {22'b0, dm_addr}, 32'd32);
        tick();
        drive(1'b1, 1'b0, 10'd36, 4'hF, 32'hB0000004);
        check("fl_stall_next", {31'b0, stall}, 32'd0);
        check("fl_drain_addr1", {22'b0, dm_addr}, 32'd33);
        tick();
        for (int k = 2; k < 5; k++) begin
            drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
            check($sformatf("fl_drain_addr%0d", k), {22'b0, dm_addr}, 32'(32 + k));
            tick();
        end
        check("fl_empty", {31'b0, empty}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fl_mem%0d", k), mem[32 + k], 32'hB0000000 + 32'(k));
        end

        // Reset with three entries queued
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 10'(48 + k), 4'hF, 32'hC0000000 + 32'(k));
            tick();
        end
        check("rq_nonempty", {31'b0, empty}, 32'd0);
        clr_n = 1'b0;
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        check("rq_rst_dm_we", {31'b0, dm_we}, 32'd0);
        tick();
        clr_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
            check($sformatf("rq_dm_we%0d", k), {31'b0, dm_we}, 32'd0);
            check($sformatf("rq_empty%0d", k), {31'b0, empty}, 32'd1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rq_mem%0d", k), mem[48 + k], 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Write buffer that sits directly upstream of the 4 KB data memory, between the datapath's memory stage and the memory's single address port. Stores with per-byte enables are queued in a small FIFO and drained into the word-wide memory one per free cycle, using read-merge-write so `sb`/`sh` work on a memory that only writes whole words. Loads always win the memory port. Load data is forwarded byte-by-byte from any queued store to the same word, so the datapath never sees stale data and never stalls on a load.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥ 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `clr_n` input 1: reset, synchronous, active-low.
- `cpu_addr` input [11:2]: word address of the load or store.
- `cpu_be` input [3:0]: byte enables for a store. Bit i selects byte lane [8i+7:8i].
- `cpu_wdata` input [31:0]: store data, already lane-aligned.
- `cpu_we` input 1: store request.
- `cpu_re` input 1: load request.
- `cpu_rdata` output [31:0]: load data (combinational).
- `stall` output 1: store not accepted this cycle; the datapath holds the instruction.
- `empty` output 1: FIFO holds no entries.
- `dm_addr` output [11:2]: memory word address.
- `dm_din` output [31:0]: memory write data.
- `dm_we` output 1: memory write enable.
- `dm_dout` input [31:0]: memory combinational read data.

## Operation
**Storage**
- `DEPTH` entries, each holding {addr[11:2], be[3:0], data[31:0]}.
- `head` and `tail` pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- `full` = (count == DEPTH); `empty` = (count == 0).

**Store push**
- Push when `cpu_we & ~full`: write entry[tail], then tail+1.
- `stall` = `cpu_we & full` (combinational). A stalled store is not enqueued.
- A store with `cpu_be`=0 is pushed and drained as a no-op write.

**Port arbitration**
- If `cpu_re`: `dm_addr`=`cpu_addr`, `dm_we`=0, no drain this cycle.
- Else if `~empty`: drain the head entry.
  - `dm_addr`=entry[head].addr.
  - `dm_din` lane i = be[i] ? data lane i : `dm_dout` lane i.
  - `dm_we`=1; pop (head+1).
- Else: `dm_addr`=`cpu_addr`, `dm_we`=0, `dm_din`=0.

**Push and pop in the same cycle**
- `count` is unchanged.
- When full, the drain still pops, but `stall` stays 1 for that cycle. The store is accepted the next cycle, so there is no combinational full→not-full bypass.

**Load forwarding**
- Start from `dm_dout`.
- Visit valid entries oldest to youngest. Where entry.addr == `cpu_addr`, overlay each lane whose be[i]=1.
- The youngest store wins per byte.
- `cpu_rdata` is meaningful only while `cpu_re`=1.

**Illegal input**
- `cpu_re` & `cpu_we` together is illegal. The block treats it as a store: push/stall as above, no drain, `cpu_rdata` undefined.

**Reset**
- While `clr_n`=0: `dm_we` is forced to 0 and `stall` to 0.
- On the edge: head=tail=count=0 and all queued stores are discarded.
- Reset wins over a simultaneous push or pop.

## Timing
- Reset values: `empty`=1, `stall`=0, `dm_we`=0, `dm_din`=0, `dm_addr`=`cpu_addr`.
- Store accepted at edge N is visible to a load at cycle N+1 through forwarding.
- It reaches memory no earlier than edge N+1, at the first cycle without `cpu_re` in which it is at the head.
- Drain rate is at most 1 entry per cycle. Drain latency is unbounded under continuous loads. This is correct by construction because forwarding covers it.
- `cpu_rdata`, `stall` and all `dm_*` outputs are combinational from inputs and registered state. There are no registered outputs.
- `empty` and `full` reflect registered `count` only.

## Test plan
- **Reset:** hold `clr_n`=0 for 2 cycles with `cpu_we`=1 → `empty`=1, `dm_we`=0, `stall`=0. After release, count=0.
- **Byte merge:** memory word 0x11223344 at addr 5; store be=4'b0010, data=0x0000AA00 → drain writes 0x1122AA44 at addr 5.
- **Forwarding:** store be=1111 data=0xDEADBEEF at addr 3 at edge N; load addr 3 on every cycle from N+1 → `cpu_rdata`=0xDEADBEEF every cycle, `dm_we`=0 throughout, `empty`=0.
- **Youngest wins per byte:** queue be=1111 0x01020304, then be=0001 0x000000FF, both at addr 7; memory holds 0 → load returns 0x010203FF.
- **Full and wrap:**
  - Issue 4 stores with `cpu_re`=0 → the first drains while the next is pushed, so the FIFO never fills.
  - Repeat with loads interleaved so the FIFO reaches 4; a 5th store sees `stall`=1 for exactly 1 cycle (drain that cycle) and is accepted on the next edge.
  - Pointers wrap and memory ends with all 5 words correct, in order.
- **Reset mid-queue:** with 3 entries queued, pulse `clr_n` low for 1 cycle → no further `dm_we` occurs, `empty`=1, and memory holds only the words drained before reset.
